// File: rtl/modbus_pkg.sv
// Modbus RTU response transmitter: shared frame-length constants and FSM states.
// Frames are serialised MSB-first from a 13-byte left-justified shift register.
package modbus_pkg;

  localparam int FRAME_W     = 104;
  localparam int MAX_BYTES   = 13;
  localparam int LEN_06      = 8;
  localparam int LEN_EXP     = 5;
  localparam int LEN_RD_BASE = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } state_t;

  function automatic logic [3:0] rd_len(input logic [7:0] q);
    return 4'(LEN_RD_BASE + 2 * int'(q));
  endfunction

endpackage

// File: rtl/modbus_rsp_tx.sv
// Modbus RTU slave response serialiser: latches one pre-built frame, feeds
// it byte by byte to the UART, then holds the line silent for the frame gap.
module modbus_rsp_tx
  import modbus_pkg::*;
#(
  parameter int GAP_CYCLES = 4000,
  parameter int MAX_QTY    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tx_06_rp_start,
  input  logic         tx_exp_rp_start,
  input  logic         tx_03_04_rp_start,
  input  logic [63:0]  code06_response,
  input  logic [39:0]  exception_seq,
  input  logic [103:0] code03_04_response,
  input  logic [7:0]   tx_quantity,
  output logic [7:0]   uart_tx_data,
  output logic         uart_tx_start,
  input  logic         uart_tx_done,
  output logic         rsp_busy,
  output logic         rsp_frame_done,
  output logic         rsp_drop
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t               state;
  state_t               state_d;
  logic [FRAME_W-1:0]   shreg;
  logic [3:0]           byte_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 q_ok;
  logic [3:0]           rd_n;
  logic [6:0]           rd_sh;
  logic                 any_start;
  logic                 acc_exp;
  logic                 acc_06;
  logic                 acc_rd;

  assign q_ok = (tx_quantity != 8'd0) &&
                (tx_quantity <= 8'(MAX_QTY));
  assign rd_n = rd_len(tx_quantity);
  // Shift that left-justifies a short read frame in the 13-byte register
  assign rd_sh = 7'((MAX_BYTES - int'(rd_n)) * 8);
  assign any_start = tx_exp_rp_start | tx_06_rp_start |
                     tx_03_04_rp_start;
  assign rsp_busy = (state != IDLE);

  always_comb begin
    state_d        = state;
    acc_exp        = 1'b0;
    acc_06         = 1'b0;
    acc_rd         = 1'b0;
    rsp_drop       = 1'b0;
    rsp_frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_exp_rp_start) begin
          acc_exp  = 1'b1;
          rsp_drop = tx_06_rp_start | tx_03_04_rp_start;
        end else if (tx_06_rp_start) begin
          acc_06   = 1'b1;
          rsp_drop = tx_03_04_rp_start;
        end else if (tx_03_04_rp_start) begin
          acc_rd   = q_ok;
          rsp_drop = !q_ok;
        end
        if (acc_exp | acc_06 | acc_rd) state_d = SEND;
      end
      SEND: begin
        rsp_drop = any_start;
        state_d  = WAIT;
      end
      WAIT: begin
        rsp_drop = any_start;
        if (uart_tx_done)
          state_d = (byte_cnt == 4'd1) ? GAP : SEND;
      end
      GAP: begin
        rsp_drop = any_start;
        if (gap_cnt == GAP_LAST) begin
          rsp_frame_done = 1'b1;
          state_d        = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      byte_cnt      <= '0;
      gap_cnt       <= '0;
      uart_tx_data  <= '0;
      uart_tx_start <= 1'b0;
    end else begin
      state         <= state_d;
      uart_tx_start <= (state == SEND);
      if (acc_exp) begin
        shreg    <= {exception_seq, 64'd0};
        byte_cnt <= 4'(LEN_EXP);
      end else if (acc_06) begin
        shreg    <= {code06_response, 40'd0};
        byte_cnt <= 4'(LEN_06);
      end else if (acc_rd) begin
        shreg    <= code03_04_response << rd_sh;
        byte_cnt <= rd_n;
      end
      if (state == SEND)
        uart_tx_data <= shreg[FRAME_W-1 -: 8];
      if (state == WAIT && uart_tx_done) begin
        shreg    <= shreg << 8;
        byte_cnt <= byte_cnt - 4'd1;
        gap_cnt  <= '0;
      end
      if (state == GAP && gap_cnt != GAP_LAST)
        gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_modbus_rsp_tx.sv
// Testbench for modbus_rsp_tx: table of frame vectors plus hand-written
// mid-frame start and mid-frame reset sequences.
module tb_modbus_rsp_tx;

  localparam int GAP = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tx_06_rp_start = 1'b0;
  logic         tx_exp_rp_start = 1'b0;
  logic         tx_03_04_rp_start = 1'b0;
  logic [63:0]  code06_response = '0;
  logic [39:0]  exception_seq = '0;
  logic [103:0] code03_04_response = '0;
  logic [7:0]   tx_quantity = '0;
  logic [7:0]   uart_tx_data;
  logic         uart_tx_start;
  logic         uart_tx_done = 1'b0;
  logic         rsp_busy;
  logic         rsp_frame_done;
  logic         rsp_drop;

  modbus_rsp_tx #(.GAP_CYCLES(GAP), .MAX_QTY(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .tx_06_rp_start     (tx_06_rp_start),
    .tx_exp_rp_start    (tx_exp_rp_start),
    .tx_03_04_rp_start  (tx_03_04_rp_start),
    .code06_response    (code06_response),
    .exception_seq      (exception_seq),
    .code03_04_response (code03_04_response),
    .tx_quantity        (tx_quantity),
    .uart_tx_data       (uart_tx_data),
    .uart_tx_start      (uart_tx_start),
    .uart_tx_done       (uart_tx_done),
    .rsp_busy           (rsp_busy),
    .rsp_frame_done     (rsp_frame_done),
    .rsp_drop           (rsp_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0;
  int nfail = 0;

  logic [7:0] cap[$];
  int n_start, n_drop, n_fd, busy_low;
  int first_cyc, last_done_cyc, fd_cyc, pcyc;
  int ucnt = 0;
  bit track_busy = 0;

  // UART model and monitor: done 10 cycles after each start
  always @(negedge clk) begin
    uart_tx_done = 1'b0;
    if (!rst_n) begin
      ucnt = 0;
    end else if (uart_tx_start) begin
      cap.push_back(uart_tx_data);
      if (n_start == 0) first_cyc = cyc;
      n_start++;
      ucnt = 10;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        uart_tx_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (rsp_drop) n_drop++;
    if (track_busy && !rsp_busy) busy_low++;
    if (rsp_frame_done) begin
      n_fd++;
      fd_cyc = cyc;
      track_busy = 0;
    end
  end

  typedef struct {
    string        name;
    logic [2:0]   starts;
    logic [63:0]  d06;
    logic [39:0]  dexp;
    logic [103:0] drd;
    logic [7:0]   q;
    int           len;
    logic [103:0] exp_vec;
    int           drop;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cap.delete();
    n_start = 0;
    n_drop = 0;
    n_fd = 0;
    busy_low = 0;
    first_cyc = -1;
    last_done_cyc = -1;
    fd_cyc = -1;
  endtask

  task automatic pulse(input logic [2:0] s, input bit trk);
    @(posedge clk);
    #1;
    {tx_exp_rp_start, tx_06_rp_start, tx_03_04_rp_start} = s;
    pcyc = cyc;
    @(posedge clk);
    #1;
    {tx_exp_rp_start, tx_06_rp_start, tx_03_04_rp_start} = 3'b000;
    if (trk) track_busy = 1;
  endtask

  task automatic wait_fd(input string name, input int limit);
    for (int i = 0; i < limit && n_fd == 0; i++) @(posedge clk);
    chk({name, " frame_done_seen"}, 128'(n_fd > 0), 128'd1);
  endtask

  task automatic wait_starts(input string name, input int n);
    for (int i = 0; i < 200 && n_start < n; i++) @(posedge clk);
    chk({name, " start_count_reached"}, 128'(n_start >= n), 128'd1);
  endtask

  function automatic logic [103:0] cap_vec();
    logic [103:0] v = '0;
    for (int i = 0; i < cap.size() && i < 13; i++)
      v[103 - 8*i -: 8] = cap[i];
    return v;
  endfunction

  function automatic vec_t mk(input string nm, input logic [2:0] s,
                              input logic [103:0] drd, input logic [7:0] q,
                              input int len, input logic [103:0] ev,
                              input int drop);
    vec_t v;
    v.name = nm;
    v.starts = s;
    v.d06 = 64'h010600010003980B;
    v.dexp = 40'h018302C0F1;
    v.drd = drd;
    v.q = q;
    v.len = len;
    v.exp_vec = ev;
    v.drop = drop;
    return v;
  endfunction

  localparam logic [103:0] EXC_V = {40'h018302C0F1, 64'd0};
  localparam logic [103:0] F06_V = {64'h010600010003980B, 40'd0};
  localparam logic [103:0] Q2_D = {32'hDEADBEEF, 72'h010304000A01027A3B};
  localparam logic [103:0] Q2_V = {72'h010304000A01027A3B, 32'd0};
  localparam logic [103:0] Q4_D = 104'h01040800112233445566_77ABCD;
  localparam logic [103:0] Q1_D = {48'hA5A5A5A5A5A5, 56'h0103021234B533};
  localparam logic [103:0] Q1_V = {56'h0103021234B533, 48'd0};

  initial begin
    vecs[0] = mk("exc",      3'b100, Q2_D, 8'd2, 5,  EXC_V, 0);
    vecs[1] = mk("f06",      3'b010, Q2_D, 8'd2, 8,  F06_V, 0);
    vecs[2] = mk("rd_q2",    3'b001, Q2_D, 8'd2, 9,  Q2_V,  0);
    vecs[3] = mk("rd_q4",    3'b001, Q4_D, 8'd4, 13, Q4_D,  0);
    vecs[4] = mk("rd_q1",    3'b001, Q1_D, 8'd1, 7,  Q1_V,  0);
    vecs[5] = mk("rd_q0",    3'b001, Q4_D, 8'd0, 0,  '0,    1);
    vecs[6] = mk("rd_q5",    3'b001, Q4_D, 8'd5, 0,  '0,    1);
    vecs[7] = mk("exp_06",   3'b110, Q2_D, 8'd2, 5,  EXC_V, 1);
    vecs[8] = mk("exp_all",  3'b111, Q2_D, 8'd2, 5,  EXC_V, 1);
    vecs[9] = mk("f06_rd",   3'b011, Q2_D, 8'd2, 8,  F06_V, 1);

    #12;
    chk("reset_outputs",
        128'({uart_tx_data, uart_tx_start, rsp_busy,
              rsp_frame_done, rsp_drop}), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      code06_response    = vecs[k].d06;
      exception_seq      = vecs[k].dexp;
      code03_04_response = vecs[k].drd;
      tx_quantity        = vecs[k].q;
      clear_mon();
      pulse(vecs[k].starts, vecs[k].len > 0);
      if (vecs[k].len > 0) wait_fd(vecs[k].name, 600);
      else repeat (40) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk({vecs[k].name, " byte_count"}, 128'(n_start), 128'(vecs[k].len));
      chk({vecs[k].name, " bytes"}, 128'(cap_vec()), 128'(vecs[k].exp_vec));
      chk({vecs[k].name, " drop_count"}, 128'(n_drop), 128'(vecs[k].drop));
      chk({vecs[k].name, " frame_done_count"}, 128'(n_fd),
          128'(vecs[k].len > 0));
      chk({vecs[k].name, " busy_after"}, 128'(rsp_busy), 128'd0);
      if (vecs[k].len > 0) begin
        chk({vecs[k].name, " first_latency"}, 128'(first_cyc - pcyc), 128'd2);
        chk({vecs[k].name, " gap_len"}, 128'(fd_cyc - last_done_cyc),
            128'(GAP));
        chk({vecs[k].name, " busy_low_in_frame"}, 128'(busy_low), 128'd0);
      end
    end

    // 06 start while an exception frame is in flight; inputs changed too
    exception_seq = 40'h018302C0F1;
    clear_mon();
    pulse(3'b100, 1);
    exception_seq = 40'h0;
    wait_starts("midframe", 2);
    pulse(3'b010, 1);
    wait_fd("midframe", 600);
    repeat (3) @(posedge clk);
    #1;
    chk("midframe drop_count", 128'(n_drop), 128'd1);
    chk("midframe bytes", 128'(cap_vec()), 128'(EXC_V));
    chk("midframe byte_count", 128'(n_start), 128'd5);
    chk("midframe frame_done_count", 128'(n_fd), 128'd1);

    // Reset during byte 3 of a 06 frame, then a clean resend
    code06_response = 64'h010600010003980B;
    clear_mon();
    pulse(3'b010, 1);
    wait_starts("reset_mid", 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    track_busy = 0;
    #1;
    chk("reset_mid outputs",
        128'({uart_tx_data, uart_tx_start, rsp_busy,
              rsp_frame_done}), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    pulse(3'b010, 1);
    wait_fd("after_reset", 600);
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset bytes", 128'(cap_vec()), 128'(F06_V));
    chk("after_reset byte_count", 128'(n_start), 128'd8);
    chk("after_reset first_latency", 128'(first_cyc - pcyc), 128'd2);
    chk("after_reset busy_low", 128'(busy_low), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
